color_processor_core: RTL and testbench

//  Holds four 24-bit RGB colours, one per screen quadrant (0=TL,1=TR,2=BL,3=BR).

---
 rtl/color_processor_core.sv | 143 ++++++++++++++
 tb/tb_color_processor_core.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/color_processor_core.sv
// color_processor_core
// Stores one RGB colour per screen quadrant, applies the switch-selected
// effect (identity / invert / gray / rotate) and the horizontal/vertical
// quadrant swaps, and presents the registered result to the VGA pixel mux.
module color_processor_core #(
    parameter int unsigned ROT_PERIOD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SW0,
    input  logic        SW1,
    input  logic        swap_h,
    input  logic        swap_v,
    input  logic        color_valid,
    input  logic [23:0] rgb0,
    input  logic [23:0] rgb1,
    input  logic [23:0] rgb2,
    input  logic [23:0] rgb3,
    output logic [23:0] ch0,
    output logic [23:0] ch1,
    output logic [23:0] ch2,
    output logic [23:0] ch3
);

    typedef enum logic [1:0] {
        MODE_IDENT  = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_GRAY   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    localparam int unsigned    CNT_W    = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROT_PERIOD - 1);

    mode_e            mode;
    logic [23:0]      rgb_in [4];

    logic [23:0]      c_q [4];
    logic [23:0]      c_d [4];
    logic [23:0]      ch_q [4];
    logic [23:0]      ch_d [4];
    logic             flip_h_q, flip_h_d;
    logic             flip_v_q, flip_v_d;
    logic             swap_h_prev_q, swap_h_prev_d;
    logic             swap_v_prev_q, swap_v_prev_d;
    logic [1:0]       rot_q, rot_d;
    logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic [1:0]       rot_eff;

    // Source quadrant for output k: flips mirror the index, rotation offsets it.
    function automatic logic [1:0] src_sel(input logic [1:0] k,
                                           input logic [1:0] flips,
                                           input logic [1:0] rot);
        return (k ^ flips) + rot;
    endfunction

    // Per-pixel colour effect; gray uses Y = (R + 2G + B) >> 2 on a 10-bit sum.
    function automatic logic [23:0] apply_effect(input mode_e m, input logic [23:0] p);
        logic [9:0]  luma_sum;
        logic [23:0] result;
        luma_sum = {2'b00, p[23:16]} + {1'b0, p[15:8], 1'b0} + {2'b00, p[7:0]};
        case (m)
            MODE_INVERT: result = ~p;
            MODE_GRAY:   result = {luma_sum[9:2], luma_sum[9:2], luma_sum[9:2]};
            default:     result = p;
        endcase
        return result;
    endfunction

    assign mode      = mode_e'({SW1, SW0});
    assign rgb_in[0] = rgb0;
    assign rgb_in[1] = rgb1;
    assign rgb_in[2] = rgb2;
    assign rgb_in[3] = rgb3;

    // Next-state for colour store, swap edge detection and rotation counter.
    always_comb begin
        swap_h_prev_d = swap_h;
        swap_v_prev_d = swap_v;
        flip_h_d      = flip_h_q ^ (swap_h & ~swap_h_prev_q);
        flip_v_d      = flip_v_q ^ (swap_v & ~swap_v_prev_q);

        c_d = c_q;
        if (color_valid) begin
            c_d = rgb_in;
        end

        rot_d     = '0;
        rot_cnt_d = '0;
        if (mode == MODE_ROTATE) begin
            rot_d = rot_q;
            if (rot_cnt_q == CNT_LAST) begin
                rot_cnt_d = '0;
                rot_d     = rot_q + 2'd1;
            end else begin
                rot_cnt_d = rot_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output pixel selection and effect from the current stored state.
    always_comb begin
        // rot is gated by the live mode so the first cycle after leaving
        // rotation already shows unrotated quadrants.
        rot_eff = (mode == MODE_ROTATE) ? rot_q : 2'd0;
        for (int unsigned k = 0; k < 4; k++) begin
            ch_d[k] = apply_effect(mode, c_q[src_sel(2'(k), {flip_v_q, flip_h_q}, rot_eff)]);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < 4; k++) begin
                c_q[k]  <= '0;
                ch_q[k] <= '0;
            end
            flip_h_q      <= 1'b0;
            flip_v_q      <= 1'b0;
            swap_h_prev_q <= 1'b0;
            swap_v_prev_q <= 1'b0;
            rot_q         <= '0;
            rot_cnt_q     <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                c_q[k]  <= c_d[k];
                ch_q[k] <= ch_d[k];
            end
            flip_h_q      <= flip_h_d;
            flip_v_q      <= flip_v_d;
            swap_h_prev_q <= swap_h_prev_d;
            swap_v_prev_q <= swap_v_prev_d;
            rot_q         <= rot_d;
            rot_cnt_q     <= rot_cnt_d;
        end
    end

    assign ch0 = ch_q[0];
    assign ch1 = ch_q[1];
    assign ch2 = ch_q[2];
    assign ch3 = ch_q[3];

endmodule

// File: tb/tb_color_processor_core.sv
// Directed bench for color_processor_core: hand-computed expected colours
// for load, invert, gray, swaps, rotation and mid-run reset.
module tb_color_processor_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        SW0, SW1;
    logic        swap_h, swap_v;
    logic        color_valid;
    logic [23:0] rgb0, rgb1, rgb2, rgb3;
    logic [23:0] ch0, ch1, ch2, ch3;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    color_processor_core #(.ROT_PERIOD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .SW0         (SW0),
        .SW1         (SW1),
        .swap_h      (swap_h),
        .swap_v      (swap_v),
        .color_valid (color_valid),
        .rgb0        (rgb0),
        .rgb1        (rgb1),
        .rgb2        (rgb2),
        .rgb3        (rgb3),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                        input logic [23:0] e2, input logic [23:0] e3);
        chk({tag, ".ch0"}, ch0, e0);
        chk({tag, ".ch1"}, ch1, e1);
        chk({tag, ".ch2"}, ch2, e2);
        chk({tag, ".ch3"}, ch3, e3);
    endtask

    task automatic set_rgb(input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c, input logic [23:0] d);
        rgb0 = a; rgb1 = b; rgb2 = c; rgb3 = d;
    endtask

    initial begin
        rst = 1'b0; SW0 = 1'b0; SW1 = 1'b0; swap_h = 1'b0; swap_v = 1'b0;
        color_valid = 1'b0;
        set_rgb(24'h123456, 24'h123456, 24'h123456, 24'h123456);
        step(2);
        rst = 1'b1;
        chk4("reset", 24'h0, 24'h0, 24'h0, 24'h0);

        // 1: load case-1 colours for three cycles, mode 00
        set_rgb(24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);
        color_valid = 1'b1;
        step(1);
        chk4("load_before", 24'h0, 24'h0, 24'h0, 24'h0);
        step(1);
        chk4("load_after", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);
        step(1);
        color_valid = 1'b0;
        step(1);
        chk4("load_hold", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);

        // 2: invert and back
        SW0 = 1'b1;
        step(1);
        chk4("invert", 24'h0F0F0F, 24'hACACAC, 24'h333333, 24'hCCCCCC);
        SW0 = 1'b0;
        step(1);
        chk4("invert_off", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);

        // 3: gray on primaries and white
        set_rgb(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF);
        color_valid = 1'b1;
        SW1 = 1'b1;
        step(1);
        color_valid = 1'b0;
        step(1);
        chk4("gray", 24'h3F3F3F, 24'h7F7F7F, 24'h3F3F3F, 24'hFFFFFF);

        // 4: swaps with case-1 colours, mode 00
        SW1 = 1'b0;
        set_rgb(24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);
        color_valid = 1'b1;
        step(1);
        color_valid = 1'b0;
        swap_h = 1'b1;
        step(1);
        chk4("swap_h_lat", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);
        step(1);
        chk4("swap_h", 24'h535353, 24'hF0F0F0, 24'h333333, 24'hCCCCCC);
        step(1);
        swap_h = 1'b0;
        step(1);
        chk4("swap_h_held", 24'h535353, 24'hF0F0F0, 24'h333333, 24'hCCCCCC);
        swap_v = 1'b1;
        step(1);
        swap_v = 1'b0;
        step(1);
        chk4("swap_hv", 24'h333333, 24'hCCCCCC, 24'h535353, 24'hF0F0F0);
        swap_h = 1'b1; swap_v = 1'b1;
        step(1);
        swap_h = 1'b0; swap_v = 1'b0;
        step(1);
        chk4("swap_both_clear", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);

        // Simultaneous load and swap edge
        set_rgb(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF);
        color_valid = 1'b1; swap_h = 1'b1;
        step(1);
        color_valid = 1'b0; swap_h = 1'b0;
        step(1);
        chk4("load_and_swap", 24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'h0000FF);
        swap_h = 1'b1;
        step(1);
        swap_h = 1'b0;
        set_rgb(24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);
        color_valid = 1'b1;
        step(1);
        color_valid = 1'b0;
        step(1);
        chk4("restore", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);

        // 5: rotation, period 16
        SW0 = 1'b1; SW1 = 1'b1;
        step(1);
        chk("rot_e1", ch0, 24'hF0F0F0);
        step(15);
        chk("rot_e16", ch0, 24'hF0F0F0);
        step(1);
        chk4("rot_e17", 24'h535353, 24'hCCCCCC, 24'h333333, 24'hF0F0F0);
        step(16);
        chk("rot_e33", ch0, 24'hCCCCCC);
        step(16);
        chk("rot_e49", ch0, 24'h333333);
        step(16);
        chk("rot_wrap", ch0, 24'hF0F0F0);
        step(16);
        chk("rot_e81", ch0, 24'h535353);
        SW0 = 1'b0; SW1 = 1'b0;
        step(1);
        chk4("rot_leave", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);
        SW0 = 1'b1; SW1 = 1'b1;
        step(16);
        chk("rot_reenter_e16", ch0, 24'hF0F0F0);
        step(1);
        chk("rot_reenter_e17", ch0, 24'h535353);

        // 6: reset mid-rotation with both flips set
        swap_h = 1'b1; swap_v = 1'b1;
        step(1);
        swap_h = 1'b0; swap_v = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk4("mid_reset", 24'h0, 24'h0, 24'h0, 24'h0);
        step(1);
        chk4("mid_reset_cleared", 24'h0, 24'h0, 24'h0, 24'h0);
        SW0 = 1'b0; SW1 = 1'b0;
        color_valid = 1'b1;
        step(1);
        color_valid = 1'b0;
        step(1);
        chk4("reload", 24'hF0F0F0, 24'h535353, 24'hCCCCCC, 24'h333333);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
